// File: rtl/aes_pkg.sv
// Shared AES constants: key-size encodings, schedule lengths and round-constant seeds.
// Helpers map a (normalised) mode onto its sequence length and reverse seed.
package aes_pkg;

   localparam logic [1:0] AES128 = 2'd0;
   localparam logic [1:0] AES192 = 2'd1;
   localparam logic [1:0] AES256 = 2'd2;

   localparam int LEN_128 = 10;
   localparam int LEN_192 = 8;
   localparam int LEN_256 = 7;

   localparam logic [7:0] SEED_128  = 8'h36;
   localparam logic [7:0] SEED_192  = 8'h80;
   localparam logic [7:0] SEED_256  = 8'h40;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   // The reserved encoding runs the AES-128 schedule.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? AES128 : m;
   endfunction

   function automatic logic [3:0] last_idx(input logic [1:0] m);
      case (m)
         AES192:  return 4'(LEN_192 - 1);
         AES256:  return 4'(LEN_256 - 1);
         default: return 4'(LEN_128 - 1);
      endcase
   endfunction

   function automatic logic [7:0] rev_seed(input logic [1:0] m);
      case (m)
         AES192:  return SEED_192;
         AES256:  return SEED_256;
         default: return SEED_128;
      endcase
   endfunction

endpackage

// File: rtl/aes_gf_xtime.sv
// GF(2^8) multiply-by-x and its inverse over the AES polynomial x^8+x^4+x^3+x+1.
// Purely combinational so MixColumns can reuse it.
module aes_gf_xtime (
   input  logic [7:0] b,
   input  logic       inv,
   output logic [7:0] y
);

   logic [7:0] fwd;
   logic [7:0] bwd;

   assign fwd = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   // An odd value had the reduction applied on the way up, so undo it first.
   assign bwd = b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
   assign y   = inv ? bwd : fwd;

endmodule

// File: rtl/aes_rcon_seq.sv
// AES round-constant sequencer: forward or reverse rcon walk for 128/192/256-bit keys,
// stepped by adv, restarted by kld, with the byte placed in the top of out.
module aes_rcon_seq
   import aes_pkg::*;
#(
   parameter int OUT_W = 32,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             kld,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             adv,
   output logic [OUT_W-1:0] out,
   output logic [CNT_W-1:0] rcnt,
   output logic             busy,
   output logic             last
);

   ctrl_state_t      state_reg;
   logic [7:0]       byte_reg;
   logic [7:0]       byte_next;
   logic [CNT_W-1:0] rcnt_reg;
   logic             last_reg;
   logic [1:0]       mode_reg;
   logic             dir_reg;

   logic [1:0]       kld_mode;
   logic [CNT_W-1:0] kld_idx;
   logic [CNT_W-1:0] run_idx;
   logic [CNT_W-1:0] rcnt_inc;
   logic [CNT_W-1:0] rcnt_dec;

   assign kld_mode = norm_mode(mode);
   assign kld_idx  = CNT_W'(last_idx(kld_mode));
   assign run_idx  = CNT_W'(last_idx(mode_reg));
   assign rcnt_inc = rcnt_reg + CNT_W'(1);
   assign rcnt_dec = rcnt_reg - CNT_W'(1);

   aes_gf_xtime u_xtime (
      .b   (byte_reg),
      .inv (dir_reg),
      .y   (byte_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         byte_reg  <= 8'h00;
         rcnt_reg  <= '0;
         last_reg  <= 1'b0;
         mode_reg  <= AES128;
         dir_reg   <= 1'b0;
      end else if (kld) begin
         state_reg <= RUN;
         mode_reg  <= kld_mode;
         dir_reg   <= dir;
         last_reg  <= 1'b0;
         if (dir) begin
            byte_reg <= rev_seed(kld_mode);
            rcnt_reg <= kld_idx;
         end else begin
            byte_reg <= RCON_INIT;
            rcnt_reg <= '0;
         end
      end else if (adv && state_reg == RUN) begin
         if (last_reg) begin
            // Exhausted: rcnt keeps the final index for observation.
            state_reg <= IDLE;
            byte_reg  <= 8'h00;
            last_reg  <= 1'b0;
         end else begin
            byte_reg <= byte_next;
            if (dir_reg) begin
               rcnt_reg <= rcnt_dec;
               last_reg <= (rcnt_dec == '0);
            end else begin
               rcnt_reg <= rcnt_inc;
               last_reg <= (rcnt_inc == run_idx);
            end
         end
      end
   end

   generate
      if (OUT_W == 8) begin : g_out_byte
         assign out = byte_reg;
      end else begin : g_out_word
         assign out = {byte_reg, {(OUT_W-8){1'b0}}};
      end
   endgenerate

   assign rcnt = rcnt_reg;
   assign busy = (state_reg == RUN);
   assign last = last_reg;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Directed bench for aes_rcon_seq: 32-bit and 8-bit output instances share one stimulus.
module tb_aes_rcon_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        kld = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        dir = 1'b0;
   logic        adv = 1'b0;

   logic [31:0] out;
   logic [3:0]  rcnt;
   logic        busy;
   logic        last;

   logic [7:0]  out8;
   logic [3:0]  rcnt8;
   logic        busy8;
   logic        last8;

   int checks = 0;
   int errors = 0;

   logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   always #5 clk = ~clk;

   aes_rcon_seq #(.OUT_W(32), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .kld(kld), .mode(mode), .dir(dir), .adv(adv),
      .out(out), .rcnt(rcnt), .busy(busy), .last(last)
   );

   aes_rcon_seq #(.OUT_W(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .kld(kld), .mode(mode), .dir(dir), .adv(adv),
      .out(out8), .rcnt(rcnt8), .busy(busy8), .last(last8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_kld(input logic [1:0] m, input logic d);
      mode = m; dir = d; kld = 1'b1;
      tick();
      kld = 1'b0;
   endtask

   task automatic do_adv();
      adv = 1'b1;
      tick();
      adv = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [7:0] b, input logic [3:0] idx,
                            input logic bsy, input logic lst);
      check({tag, ".out"},  out,  {b, 24'h0});
      check({tag, ".rcnt"}, {28'h0, rcnt}, {28'h0, idx});
      check({tag, ".busy"}, {31'h0, busy}, {31'h0, bsy});
      check({tag, ".last"}, {31'h0, last}, {31'h0, lst});
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all("reset", 8'h00, 4'd0, 1'b0, 1'b0);

      // Forward AES-128, both output widths
      do_kld(2'd0, 1'b0);
      check_all("f128_0", rc[0], 4'd0, 1'b1, 1'b0);
      check("f128_0.out8", {24'h0, out8}, {24'h0, rc[0]});
      for (int i = 1; i < 10; i++) begin
         do_adv();
         check_all($sformatf("f128_%0d", i), rc[i], 4'(i), 1'b1, (i == 9));
         check($sformatf("f128_%0d.out8", i), {24'h0, out8}, {24'h0, rc[i]});
      end
      do_adv();
      check_all("f128_done", 8'h00, 4'd9, 1'b0, 1'b0);
      check("f128_done.out8", {24'h0, out8}, 32'h0);

      // adv while idle changes nothing
      do_adv();
      check_all("idle_adv", 8'h00, 4'd9, 1'b0, 1'b0);

      // Reverse AES-256
      do_kld(2'd2, 1'b1);
      check_all("r256_6", 8'h40, 4'd6, 1'b1, 1'b0);
      for (int i = 5; i >= 0; i--) begin
         do_adv();
         check_all($sformatf("r256_%0d", i), rc[i], 4'(i), 1'b1, (i == 0));
      end
      do_adv();
      check_all("r256_done", 8'h00, 4'd0, 1'b0, 1'b0);

      // Reverse AES-192
      do_kld(2'd1, 1'b1);
      check_all("r192_7", 8'h80, 4'd7, 1'b1, 1'b0);
      do_adv();
      check_all("r192_6", 8'h40, 4'd6, 1'b1, 1'b0);

      // Mid-sequence restart into reverse AES-128
      do_kld(2'd0, 1'b0);
      for (int i = 0; i < 4; i++) do_adv();
      check_all("restart_pre", 8'h10, 4'd4, 1'b1, 1'b0);
      do_kld(2'd0, 1'b1);
      check_all("restart", 8'h36, 4'd9, 1'b1, 1'b0);

      // mode/dir changes while busy are ignored until next kld
      mode = 2'd2; dir = 1'b0;
      do_adv();
      check_all("latched", 8'h1b, 4'd8, 1'b1, 1'b0);

      // kld and adv together: only the load takes effect
      mode = 2'd0; dir = 1'b0; kld = 1'b1; adv = 1'b1;
      tick();
      kld = 1'b0; adv = 1'b0;
      check_all("kld_adv", 8'h01, 4'd0, 1'b1, 1'b0);

      // Reserved mode runs as AES-128
      do_kld(2'd3, 1'b1);
      check_all("m3_rev", 8'h36, 4'd9, 1'b1, 1'b0);
      do_kld(2'd3, 1'b0);
      for (int i = 0; i < 9; i++) do_adv();
      check_all("m3_fwd_last", 8'h36, 4'd9, 1'b1, 1'b1);

      // rst beats a simultaneous kld
      rst = 1'b1; kld = 1'b1; mode = 2'd1; dir = 1'b1;
      tick();
      rst = 1'b0; kld = 1'b0;
      check_all("rst_kld", 8'h00, 4'd0, 1'b0, 1'b0);
      check("rst_kld.busy8", {31'h0, busy8}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
